// File: rtl/trig_id_capture.sv
// rtl/trig_id_capture.sv - serial trigger-ID receiver with first-word fall-through ID FIFO
module trig_id_capture #(
  parameter int ID_WIDTH   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 1023
) (
  input  logic                        pll_clk,
  input  logic                        reset,
  input  logic                        trig_in,
  input  logic                        trig_id,
  input  logic                        ext_clk,
  input  logic                        rd_en,
  output logic [ID_WIDTH-1:0]         rd_data,
  output logic                        fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        irq,
  output logic                        busy,
  output logic [7:0]                  overflow_cnt,
  output logic [7:0]                  timeout_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(ID_WIDTH);

  typedef enum logic [1:0] {IDLE, CAPTURE, PUSH} state_t;

  state_t              state, state_nxt;
  logic                trig_s1, trig_s2, trig_s3;
  logic                id_s1, id_s2;
  logic                eclk_s1, eclk_s2, eclk_s3;
  logic [ID_WIDTH-1:0] shreg;
  logic [BW-1:0]       bit_cnt;
  logic [TW-1:0]       timer;
  logic [AW:0]         wr_ptr, rd_ptr;
  logic [ID_WIDTH-1:0] mem [FIFO_DEPTH];

  logic trig_rise, clk_fall, last_bit, capture_done, capture_abort;
  logic fifo_full, do_pop, do_push, start_capture;

  assign trig_rise     = trig_s2 & ~trig_s3;
  assign clk_fall      = ~eclk_s2 & eclk_s3;
  assign last_bit      = (bit_cnt == BW'(ID_WIDTH - 1));
  assign capture_done  = (state == CAPTURE) & clk_fall & last_bit;
  assign capture_abort = (state == CAPTURE) & ~capture_done & (timer == TW'(TIMEOUT));
  assign start_capture = ((state == IDLE) | (state == PUSH)) & trig_rise;

  assign fifo_count = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign irq        = ~fifo_empty;
  assign busy       = (state != IDLE);
  assign rd_data    = mem[rd_ptr[AW-1:0]];

  // A full FIFO still accepts the new ID when the same cycle frees a slot.
  assign do_pop  = rd_en & ~fifo_empty;
  assign do_push = (state == PUSH) & (~fifo_full | do_pop);

  // Two-stage synchronisers plus history flops for edge detection.
  always_ff @(posedge pll_clk or negedge reset) begin
    if (!reset) begin
      trig_s1 <= 1'b0; trig_s2 <= 1'b0; trig_s3 <= 1'b0;
      id_s1   <= 1'b0; id_s2   <= 1'b0;
      eclk_s1 <= 1'b0; eclk_s2 <= 1'b0; eclk_s3 <= 1'b0;
    end else begin
      trig_s1 <= trig_in; trig_s2 <= trig_s1; trig_s3 <= trig_s2;
      id_s1   <= trig_id; id_s2   <= id_s1;
      eclk_s1 <= ext_clk; eclk_s2 <= eclk_s1; eclk_s3 <= eclk_s2;
    end
  end

  // FSM state register.
  always_ff @(posedge pll_clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a completing bit in the timeout cycle takes priority over the abort.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trig_rise) state_nxt = CAPTURE;
      CAPTURE: begin
        if (capture_done)       state_nxt = PUSH;
        else if (capture_abort) state_nxt = IDLE;
      end
      PUSH:    state_nxt = trig_rise ? CAPTURE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register, bit counter and capture timer.
  always_ff @(posedge pll_clk or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      timer   <= '0;
    end else if (start_capture) begin
      shreg   <= '0;
      bit_cnt <= '0;
      timer   <= '0;
    end else if (state == CAPTURE) begin
      timer <= timer + 1'b1;
      if (clk_fall) begin
        shreg   <= {shreg[ID_WIDTH-2:0], id_s2};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Saturating drop and abort counters.
  always_ff @(posedge pll_clk or negedge reset) begin
    if (!reset) begin
      overflow_cnt <= '0;
      timeout_cnt  <= '0;
    end else begin
      if ((state == PUSH) && !do_push && (overflow_cnt != 8'hFF))
        overflow_cnt <= overflow_cnt + 1'b1;
      if (capture_abort && (timeout_cnt != 8'hFF))
        timeout_cnt <= timeout_cnt + 1'b1;
    end
  end

  // FIFO pointers carry one wrap bit above the address.
  always_ff @(posedge pll_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents need no reset because the pointers gate visibility.
  always_ff @(posedge pll_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= shreg;
  end

endmodule

// File: tb/tb_trig_id_capture.sv
// tb/tb_trig_id_capture.sv - self-checking bench for trig_id_capture
module tb_trig_id_capture;

  logic        pll_clk = 1'b0;
  logic        rst_n;
  logic        trig_in, trig_id, ext_clk, rd_en;
  logic [15:0] rd_data;
  logic        fifo_empty, irq, busy;
  logic [3:0]  fifo_count;
  logic [7:0]  overflow_cnt, timeout_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  int exp_ovf = 0;
  int exp_tmo = 0;

  typedef struct {
    logic [15:0] id;
    logic [15:0] exp_data;
    int          exp_count;
  } vec_t;

  vec_t vecs[4];

  trig_id_capture #(.ID_WIDTH(16), .FIFO_DEPTH(8), .TIMEOUT(1023)) dut (
    .pll_clk(pll_clk), .reset(rst_n), .trig_in(trig_in), .trig_id(trig_id),
    .ext_clk(ext_clk), .rd_en(rd_en), .rd_data(rd_data), .fifo_empty(fifo_empty),
    .fifo_count(fifo_count), .irq(irq), .busy(busy),
    .overflow_cnt(overflow_cnt), .timeout_cnt(timeout_cnt)
  );

  always #5 pll_clk = ~pll_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_trig();
    trig_in = 1'b1;
    repeat (4) @(negedge pll_clk);
    trig_in = 1'b0;
    repeat (2) @(negedge pll_clk);
  endtask

  // Returns on the negedge at which the last falling ext_clk edge is driven.
  task automatic send_bits(input logic [15:0] id, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      trig_id = id[15-i];
      ext_clk = 1'b1;
      repeat (4) @(negedge pll_clk);
      ext_clk = 1'b0;
      if (i != nbits - 1) repeat (4) @(negedge pll_clk);
    end
  endtask

  task automatic send_frame(input logic [15:0] id);
    pulse_trig();
    send_bits(id, 16);
  endtask

  task automatic model_push(input logic [15:0] id);
    if (exp_q.size() < 8) exp_q.push_back(id);
    else if (exp_ovf < 255) exp_ovf++;
  endtask

  task automatic read_one(input string name);
    logic [15:0] e;
    check({name, "_nonempty"}, {31'd0, fifo_empty}, 32'd0);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got read with empty scoreboard expected queued id", name);
    end else begin
      e = exp_q.pop_front();
      check(name, {16'd0, rd_data}, {16'd0, e});
    end
    rd_en = 1'b1;
    @(negedge pll_clk);
    rd_en = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_empty"}, {31'd0, fifo_empty}, 32'd1);
    check({tag, "_count"}, {28'd0, fifo_count}, 32'd0);
    check({tag, "_irq"},   {31'd0, irq},        32'd0);
    check({tag, "_busy"},  {31'd0, busy},       32'd0);
    check({tag, "_ovf"},   {24'd0, overflow_cnt}, 32'd0);
    check({tag, "_tmo"},   {24'd0, timeout_cnt},  32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no completion expected finish within 2ms");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{id: 16'hA5C3, exp_data: 16'hA5C3, exp_count: 1};
    vecs[1] = '{id: 16'h0000, exp_data: 16'h0000, exp_count: 1};
    vecs[2] = '{id: 16'hFFFF, exp_data: 16'hFFFF, exp_count: 1};
    vecs[3] = '{id: 16'h8001, exp_data: 16'h8001, exp_count: 1};

    rst_n = 1'b0; trig_in = 1'b0; trig_id = 1'b0; ext_clk = 1'b0; rd_en = 1'b0;
    repeat (3) @(negedge pll_clk);
    check_reset_state("por");
    rst_n = 1'b1;
    repeat (3) @(negedge pll_clk);

    // Single frames: irq latency, head data, pop back to empty.
    foreach (vecs[k]) begin
      send_frame(vecs[k].id);
      model_push(vecs[k].id);
      repeat (3) @(negedge pll_clk);
      check("irq_early", {31'd0, irq}, 32'd0);
      @(negedge pll_clk);
      check("irq_latency", {31'd0, irq}, 32'd1);
      check("vec_count", {28'd0, fifo_count}, vecs[k].exp_count);
      check("vec_data", {16'd0, rd_data}, {16'd0, vecs[k].exp_data});
      read_one("vec_read");
      check("vec_empty", {31'd0, fifo_empty}, 32'd1);
      check("vec_irq_off", {31'd0, irq}, 32'd0);
    end

    // Overflow: nine IDs into eight slots.
    for (int k = 1; k <= 9; k++) begin
      send_frame(16'(k));
      model_push(16'(k));
      repeat (6) @(negedge pll_clk);
    end
    check("ovf_count", {28'd0, fifo_count}, 32'd8);
    check("ovf_cnt", {24'd0, overflow_cnt}, 32'(exp_ovf));
    for (int k = 0; k < 8; k++) read_one("ovf_read");
    check("ovf_drained", {31'd0, fifo_empty}, 32'd1);

    // Timeout: five bits then silence.
    pulse_trig();
    send_bits(16'hF800, 5);
    repeat (500) @(negedge pll_clk);
    check("tmo_busy_mid", {31'd0, busy}, 32'd1);
    repeat (600) @(negedge pll_clk);
    exp_tmo++;
    check("tmo_busy_end", {31'd0, busy}, 32'd0);
    check("tmo_cnt", {24'd0, timeout_cnt}, 32'(exp_tmo));
    check("tmo_empty", {31'd0, fifo_empty}, 32'd1);
    send_frame(16'h1234);
    model_push(16'h1234);
    repeat (6) @(negedge pll_clk);
    read_one("tmo_next_read");

    // Full FIFO with a pop in the PUSH cycle: nothing dropped.
    for (int k = 0; k < 8; k++) begin
      send_frame(16'h1100 + 16'(k));
      model_push(16'h1100 + 16'(k));
      repeat (6) @(negedge pll_clk);
    end
    check("full_count", {28'd0, fifo_count}, 32'd8);
    pulse_trig();
    send_bits(16'hBEEF, 16);
    repeat (3) @(negedge pll_clk);
    check("full_in_push", {31'd0, busy}, 32'd1);
    read_one("full_pop_in_push");
    exp_q.push_back(16'hBEEF);
    repeat (2) @(negedge pll_clk);
    check("full_count_after", {28'd0, fifo_count}, 32'd8);
    check("full_no_ovf", {24'd0, overflow_cnt}, 32'(exp_ovf));
    for (int k = 0; k < 8; k++) read_one("full_read");

    // Trigger arriving during PUSH starts the next capture directly.
    send_frame(16'h3C3C);
    @(negedge pll_clk);
    trig_in = 1'b1;
    repeat (4) @(negedge pll_clk);
    trig_in = 1'b0;
    repeat (2) @(negedge pll_clk);
    send_bits(16'h00FF, 16);
    model_push(16'h3C3C);
    model_push(16'h00FF);
    repeat (6) @(negedge pll_clk);
    check("b2b_count", {28'd0, fifo_count}, 32'd2);
    check("b2b_tmo", {24'd0, timeout_cnt}, 32'(exp_tmo));
    check("b2b_busy", {31'd0, busy}, 32'd0);
    read_one("b2b_first");
    read_one("b2b_second");

    // Reset mid-capture with three IDs held.
    for (int k = 0; k < 3; k++) begin
      send_frame(16'h7700 + 16'(k));
      model_push(16'h7700 + 16'(k));
      repeat (6) @(negedge pll_clk);
    end
    check("pre_rst_count", {28'd0, fifo_count}, 32'd3);
    pulse_trig();
    send_bits(16'hABCD, 5);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    exp_q.delete();
    exp_ovf = 0;
    exp_tmo = 0;
    ext_clk = 1'b0;
    @(negedge pll_clk);
    rst_n = 1'b1;
    repeat (3) @(negedge pll_clk);
    send_frame(16'hCAFE);
    model_push(16'hCAFE);
    repeat (6) @(negedge pll_clk);
    check("post_rst_count", {28'd0, fifo_count}, 32'd1);
    read_one("post_rst_read");
    check("post_rst_empty", {31'd0, fifo_empty}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
